// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio-path defaults: sample/slot widths, frame length
//               and the I2S slot encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int c_DATA_W_DEFAULT = 24;
    localparam int c_SLOT_W_DEFAULT = 32;
    localparam int c_FRAME_LEN      = 2 * c_SLOT_W_DEFAULT;

    // Word-select encoding: left slot first in every frame.
    typedef enum logic [0:0] {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    function automatic int frame_len(input int slot_w);
        return 2 * slot_w;
    endfunction

endpackage : audio_pkg
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_bclk_gen
// Description : Divides clk into the I2S bit clock and strobes the clk cycle
//               on which BCLK is about to fall.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic o_bclk,
    output logic o_fall
);

    localparam int                 c_CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(BCLK_DIV - 1);

    logic [c_CNT_W-1:0] r_div_cnt;
    logic               r_bclk;
    logic               w_term;

    assign w_term = (r_div_cnt == c_TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_term) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Combinational so the consumer updates on the same edge BCLK falls.
    assign o_fall = w_term & r_bclk;
    assign o_bclk = r_bclk;

endmodule : i2s_bclk_gen
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : Stereo I2S transmitter with a one-deep sample holding register,
//               underrun signalling and clock-enable derived BCLK/LRCLK.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEFAULT,
    parameter int SLOT_W   = c_SLOT_W_DEFAULT,
    parameter int BCLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              BCLK,
    output logic              LRCLK,
    output logic              DAC_SDATA,
    output logic              frame_start,
    output logic              underrun
);

    localparam int                 c_FRAME = frame_len(SLOT_W);
    localparam int                 c_BIT_W = $clog2(c_FRAME);
    localparam logic [c_BIT_W-1:0] c_LAST  = c_BIT_W'(c_FRAME - 1);
    localparam logic [c_BIT_W-1:0] c_SLOT  = c_BIT_W'(SLOT_W);

    logic               w_fall;
    logic               w_hs;
    logic               w_frame_wrap;
    logic [c_BIT_W-1:0] w_bit_cnt_nxt;
    logic [c_BIT_W-1:0] w_b;
    logic [DATA_W-1:0]  w_act_l_nxt;
    logic [DATA_W-1:0]  w_act_r_nxt;
    logic [DATA_W-1:0]  w_word;
    logic               w_sdata_nxt;
    slot_e              w_slot;

    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_pend_l;
    logic [DATA_W-1:0]  r_pend_r;
    logic               r_pend_full;
    logic [DATA_W-1:0]  r_act_l;
    logic [DATA_W-1:0]  r_act_r;
    logic               r_lrclk;
    logic               r_sdata;
    logic               r_frame_start;
    logic               r_underrun;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk    (clk),
        .rst    (reset),
        .o_bclk (BCLK),
        .o_fall (w_fall)
    );

    assign w_hs         = s_valid & ~r_pend_full;
    assign w_frame_wrap = w_fall & (r_bit_cnt == c_LAST);

    // Serializer works from post-update state so bit 0 of a new frame already
    // sees the freshly loaded sample.
    always_comb begin
        w_bit_cnt_nxt = w_frame_wrap ? '0 : r_bit_cnt + 1'b1;
        w_act_l_nxt   = r_act_l;
        w_act_r_nxt   = r_act_r;
        if (w_frame_wrap) begin
            w_act_l_nxt = r_pend_full ? r_pend_l : '0;
            w_act_r_nxt = r_pend_full ? r_pend_r : '0;
        end
        w_slot = (w_bit_cnt_nxt >= c_SLOT) ? SLOT_RIGHT : SLOT_LEFT;
        w_b    = (w_slot == SLOT_RIGHT) ? w_bit_cnt_nxt - c_SLOT : w_bit_cnt_nxt;
        w_word = (w_slot == SLOT_RIGHT) ? w_act_r_nxt : w_act_l_nxt;
        // Slot bit 0 is the I2S delay bit; bits past DATA_W pad with zero.
        w_sdata_nxt = 1'b0;
        for (int k = 1; k <= DATA_W; k++) begin
            if (w_b == c_BIT_W'(k)) begin
                w_sdata_nxt = w_word[DATA_W-k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt     <= c_LAST;
            r_pend_l      <= '0;
            r_pend_r      <= '0;
            r_pend_full   <= 1'b0;
            r_act_l       <= '0;
            r_act_r       <= '0;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_frame_wrap;
            r_underrun    <= w_frame_wrap & ~r_pend_full;
            if (w_fall) begin
                r_bit_cnt <= w_bit_cnt_nxt;
                r_act_l   <= w_act_l_nxt;
                r_act_r   <= w_act_r_nxt;
                r_lrclk   <= w_slot;
                r_sdata   <= w_sdata_nxt;
            end
            // A handshake needs an empty holder, so it never races the drain.
            if (w_hs) begin
                r_pend_l    <= s_left;
                r_pend_r    <= s_right;
                r_pend_full <= 1'b1;
            end else if (w_frame_wrap) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign s_ready     = ~r_pend_full;
    assign LRCLK       = r_lrclk;
    assign DAC_SDATA   = r_sdata;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule : i2s_tx
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx
// Description : Self-checking bench for i2s_tx: frame-level scoreboard on the
//               default build plus a BCLK_DIV=1 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int DW        = 24;
    localparam int SW        = 32;
    localparam int DIV       = 4;
    localparam int FRAME_CYC = 4 * SW * DIV;

    typedef struct {
        logic [31:0] l_img;
        logic [31:0] r_img;
    } frame_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [31:0] l_img;
        logic [31:0] r_img;
        int          gap;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, s_valid, s_ready;
    logic [DW-1:0] s_left, s_right;
    logic          BCLK, LRCLK, DAC_SDATA, frame_start, underrun;

    logic          reset1, s_valid1, s_ready1;
    logic [DW-1:0] s_left1, s_right1;
    logic          BCLK1, LRCLK1, DAC_SDATA1, frame_start1, underrun1;

    i2s_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .BCLK(BCLK), .LRCLK(LRCLK),
        .DAC_SDATA(DAC_SDATA), .frame_start(frame_start), .underrun(underrun)
    );

    i2s_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset1), .s_valid(s_valid1), .s_ready(s_ready1),
        .s_left(s_left1), .s_right(s_right1), .BCLK(BCLK1), .LRCLK(LRCLK1),
        .DAC_SDATA(DAC_SDATA1), .frame_start(frame_start1), .underrun(underrun1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: a pair is queued once its handshake edge has passed, and
    // popped when the DUT reports the frame that should carry it.
    frame_t      sb_q[$];
    frame_t      drv_exp;
    frame_t      hs_item;
    frame_t      cur_exp;
    logic        hs_pend    = 1'b0;
    logic        prev_bclk  = 1'b0;
    logic        prev_sdata = 1'b0;
    logic        prev_reset = 1'b1;
    int          bit_idx    = -1;
    int          since_fs   = 0;
    logic        fs_valid   = 1'b0;
    logic [63:0] got_d, got_lr;

    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            hs_pend  = 1'b0;
            bit_idx  = -1;
            fs_valid = 1'b0;
            since_fs = 0;
        end else begin
            since_fs++;
            if (frame_start) begin
                if (fs_valid) check("frame_period", 64'(since_fs), 64'(FRAME_CYC));
                check("prev_frame_complete", 64'(bit_idx), 64'(-1));
                since_fs = 0;
                fs_valid = 1'b1;
                if (sb_q.size() > 0) begin
                    cur_exp = sb_q.pop_front();
                    check("underrun_with_data", 64'(underrun), 64'd0);
                end else begin
                    cur_exp = '{32'h0, 32'h0};
                    check("underrun_empty", 64'(underrun), 64'd1);
                end
                bit_idx = 0;
                got_d   = '0;
                got_lr  = '0;
            end else if (underrun) begin
                check("underrun_without_frame_start", 64'(underrun), 64'd0);
            end
            if (hs_pend) sb_q.push_back(hs_item);
            hs_pend = 1'b0;
            if (s_valid && s_ready) begin
                hs_pend = 1'b1;
                hs_item = drv_exp;
            end
            if (!prev_bclk && BCLK && bit_idx >= 0) begin
                got_d[63-bit_idx]  = DAC_SDATA;
                got_lr[63-bit_idx] = LRCLK;
                bit_idx++;
                if (bit_idx == 64) begin
                    check("frame_data", got_d, {cur_exp.l_img, cur_exp.r_img});
                    check("frame_lrclk", got_lr, {32'h0, 32'hFFFF_FFFF});
                    bit_idx = -1;
                end
            end
            if (!prev_reset && DAC_SDATA !== prev_sdata)
                check("sdata_changes_on_fall", {62'd0, prev_bclk, BCLK}, 64'd2);
        end
        prev_bclk  = BCLK;
        prev_sdata = DAC_SDATA;
        prev_reset = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 2 * FRAME_CYC);
        if (!frame_start) check("wait_frame_start_timeout", 64'(n), 64'(FRAME_CYC));
    endtask

    task automatic send(input vec_t v, output int waited, output logic fs_before);
        logic ok = 1'b0;
        waited    = 0;
        fs_before = 1'b0;
        s_left    = v.l;
        s_right   = v.r;
        drv_exp   = '{v.l_img, v.r_img};
        s_valid   = 1'b1;
        while (!ok && waited < 2 * FRAME_CYC) begin
            @(negedge clk);
            ok        = s_ready;
            fs_before = frame_start;
            tick();
            waited++;
        end
        s_valid = 1'b0;
        check("send_accepted", 64'(ok), 64'd1);
    endtask

    vec_t tbl[4];

    initial begin
        int          n, waited, cyc, k;
        logic        fsb, prevb, toggles_ok;
        logic [63:0] d1, lr1;
        vec_t        v;

        // Slot images: delay bit, 24 data bits MSB first, 7 zero pad bits.
        tbl[0] = '{24'hA5A5A5, 24'h0F0F0F, 32'h52D2D280, 32'h07878780, 10};
        tbl[1] = '{24'h123456, 24'hABCDEF, 32'h091A2B00, 32'h55E6F780, 0};
        tbl[2] = '{24'h800001, 24'h7FFFFE, 32'h40000080, 32'h3FFFFF00, 0};
        tbl[3] = '{24'hFFFFFF, 24'h000001, 32'h7FFFFF80, 32'h00000080, 0};

        reset = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        reset1 = 1'b1; s_valid1 = 1'b0; s_left1 = '0; s_right1 = '0;
        drv_exp = '{32'h0, 32'h0};
        repeat (3) tick();
        check("rst_bclk", 64'(BCLK), 64'd0);
        check("rst_lrclk", 64'(LRCLK), 64'd0);
        check("rst_sdata", 64'(DAC_SDATA), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_frame_start", 64'(frame_start), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);

        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!frame_start && n < 100);
        check("first_fs_latency", 64'(n), 64'd8);
        check("first_fs_underrun", 64'(underrun), 64'd1);
        wait_fs();

        for (int i = 0; i < 4; i++) begin
            v = tbl[i];
            repeat (v.gap) tick();
            send(v, waited, fsb);
            check("s_ready_drops", 64'(s_ready), 64'd0);
            if (waited > 1) check("held_until_after_fs", 64'(fsb), 64'd1);
        end

        // Handshake on the very edge that starts a frame with an empty holder.
        wait_fs();
        repeat (FRAME_CYC - 1) tick();
        s_left = 24'h5A5A5A; s_right = 24'hC3C3C3;
        drv_exp = '{32'h2D2D2D00, 32'h61E1E180};
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("coincident_fs", 64'(frame_start), 64'd1);
        check("coincident_underrun", 64'(underrun), 64'd1);
        check("coincident_held", 64'(s_ready), 64'd0);
        wait_fs();
        wait_fs();

        // Mid-frame reset with a sample pending that must be discarded.
        v = '{24'h3C3C3C, 24'h969696, 32'h1E1E1E00, 32'h4B4B4B00, 0};
        send(v, waited, fsb);
        n = 0;
        while (bit_idx != 41 && n < FRAME_CYC) begin tick(); n++; end
        check("reached_bit_40", 64'(bit_idx), 64'd41);
        reset = 1'b1;
        tick();
        check("mid_rst_bclk", 64'(BCLK), 64'd0);
        check("mid_rst_lrclk", 64'(LRCLK), 64'd0);
        check("mid_rst_sdata", 64'(DAC_SDATA), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd1);
        check("mid_rst_fs", 64'(frame_start), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!frame_start && n < 100);
        check("post_rst_fs_latency", 64'(n), 64'd8);
        check("post_rst_underrun", 64'(underrun), 64'd1);
        wait_fs();
        n = 0;
        while (bit_idx != -1 && n < FRAME_CYC) begin tick(); n++; end
        check("last_frame_decoded", 64'(bit_idx), 64'(-1));
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        // BCLK_DIV = 1 instance.
        reset1 = 1'b0;
        s_left1 = 24'hA5A5A5; s_right1 = 24'h0F0F0F; s_valid1 = 1'b1;
        tick();
        s_valid1 = 1'b0;
        n = 0;
        while (!frame_start1 && n < 10) begin tick(); n++; end
        check("div1_fs_seen", 64'(frame_start1), 64'd1);
        check("div1_no_underrun", 64'(underrun1), 64'd0);
        cyc = 0; k = 0; prevb = BCLK1; toggles_ok = 1'b1; d1 = '0; lr1 = '0;
        do begin
            tick();
            cyc++;
            if (BCLK1 == prevb) toggles_ok = 1'b0;
            if (BCLK1 && !prevb && k < 64) begin
                d1[63-k]  = DAC_SDATA1;
                lr1[63-k] = LRCLK1;
                k++;
            end
            prevb = BCLK1;
        end while (!frame_start1 && cyc < 300);
        check("div1_period", 64'(cyc), 64'd128);
        check("div1_toggle", 64'(toggles_ok), 64'd1);
        check("div1_bits", 64'(k), 64'd64);
        check("div1_data", d1, {32'h52D2D280, 32'h07878780});
        check("div1_lrclk", lr1, {32'h0, 32'hFFFF_FFFF});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2s_tx
`default_nettype wire
